// File: rtl/axis_hdr_insert_arbiter.sv
// Round-robin arbiter sharing one header inserter among NUM_REQ stream sources.
// Define ARB_PKT_CNT_EN to add per-source completed-packet counters (pkt_cnt).
module axis_hdr_insert_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int DATA_WD      = 32,
   parameter int DATA_BYTE_WD = DATA_WD / 8,
   parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
   parameter int REQ_WD       = $clog2(NUM_REQ)
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_REQ-1:0]                req_hdr_valid,
   input  logic [NUM_REQ*DATA_WD-1:0]        req_hdr_data,
   input  logic [NUM_REQ*DATA_BYTE_WD-1:0]   req_hdr_keep,
   input  logic [NUM_REQ*BYTE_CNT_WD-1:0]    req_hdr_cnt,
   output logic [NUM_REQ-1:0]                req_hdr_ready,
   input  logic [NUM_REQ-1:0]                req_valid,
   input  logic [NUM_REQ*DATA_WD-1:0]        req_data,
   input  logic [NUM_REQ*DATA_BYTE_WD-1:0]   req_keep,
   input  logic [NUM_REQ-1:0]                req_last,
   output logic [NUM_REQ-1:0]                req_ready,
   output logic                              valid_insert,
   output logic [DATA_WD-1:0]                data_insert,
   output logic [DATA_BYTE_WD-1:0]           keep_insert,
   output logic [BYTE_CNT_WD-1:0]            byte_insert_cnt,
   input  logic                              ready_insert,
   output logic                              valid_in,
   output logic [DATA_WD-1:0]                data_in,
   output logic [DATA_BYTE_WD-1:0]           keep_in,
   output logic                              last_in,
   input  logic                              ready_in,
   output logic [REQ_WD-1:0]                 grant_id,
   output logic                              busy
`ifdef ARB_PKT_CNT_EN
   ,
   output logic [NUM_REQ*16-1:0]             pkt_cnt
`endif
);

   localparam int unsigned NREQ = NUM_REQ;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      BODY = 2'd2
   } state_t;

   state_t              state;
   logic [REQ_WD-1:0]   rr_ptr;
   logic [REQ_WD-1:0]   winner;
   logic [REQ_WD-1:0]   next_ptr;
   logic                any_hdr;
   logic                hdr_acc;
   logic                last_acc;

   // First requesting header found scanning from rr_ptr upward, wrapping at NUM_REQ.
   always_comb begin
      int unsigned cand;
      winner  = '0;
      any_hdr = 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         cand = 32'(rr_ptr) + i;
         if (cand >= NREQ) cand = cand - NREQ;
         if (!any_hdr && req_hdr_valid[REQ_WD'(cand)]) begin
            winner  = REQ_WD'(cand);
            any_hdr = 1'b1;
         end
      end
      next_ptr = (32'(winner) == NREQ - 1) ? '0 : winner + 1'b1;
   end

   always_comb begin
      valid_insert  = 1'b0;
      valid_in      = 1'b0;
      req_hdr_ready = '0;
      req_ready     = '0;
      if (state == HDR) begin
         valid_insert            = req_hdr_valid[grant_id];
         req_hdr_ready[grant_id] = ready_insert;
      end
      if (state == BODY) begin
         valid_in            = req_valid[grant_id];
         req_ready[grant_id] = ready_in;
      end
   end

   always_comb begin
      data_insert     = req_hdr_data[32'(grant_id)*DATA_WD +: DATA_WD];
      keep_insert     = req_hdr_keep[32'(grant_id)*DATA_BYTE_WD +: DATA_BYTE_WD];
      byte_insert_cnt = req_hdr_cnt[32'(grant_id)*BYTE_CNT_WD +: BYTE_CNT_WD];
      data_in         = req_data[32'(grant_id)*DATA_WD +: DATA_WD];
      keep_in         = req_keep[32'(grant_id)*DATA_BYTE_WD +: DATA_BYTE_WD];
      last_in         = req_last[grant_id];
   end

   assign hdr_acc  = valid_insert && ready_insert;
   assign last_acc = valid_in && ready_in && last_in;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         grant_id <= '0;
         rr_ptr   <= '0;
         busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_hdr) begin
                  grant_id <= winner;
                  rr_ptr   <= next_ptr;
                  state    <= HDR;
                  busy     <= 1'b1;
               end
            end
            HDR: begin
               if (hdr_acc) state <= BODY;
            end
            BODY: begin
               if (last_acc) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef ARB_PKT_CNT_EN
   logic [15:0] cnt_q [NUM_REQ];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NREQ; i++) cnt_q[i] <= '0;
      end else if (last_acc && cnt_q[grant_id] != 16'hFFFF) begin
         cnt_q[grant_id] <= cnt_q[grant_id] + 16'd1;
      end
   end

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
      assign pkt_cnt[i*16 +: 16] = cnt_q[i];
   end
`endif

endmodule

// File: tb/tb_axis_hdr_insert_arbiter.sv
// Directed self-checking bench for axis_hdr_insert_arbiter (NUM_REQ=4, DATA_WD=32).
module tb_axis_hdr_insert_arbiter;

   localparam int N = 4;
   localparam int W = 32;
   localparam int K = 4;
   localparam int C = 2;
   localparam int R = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_hdr_valid;
   logic [N*W-1:0]  req_hdr_data;
   logic [N*K-1:0]  req_hdr_keep;
   logic [N*C-1:0]  req_hdr_cnt;
   logic [N-1:0]    req_hdr_ready;
   logic [N-1:0]    req_valid;
   logic [N*W-1:0]  req_data;
   logic [N*K-1:0]  req_keep;
   logic [N-1:0]    req_last;
   logic [N-1:0]    req_ready;
   logic            valid_insert;
   logic [W-1:0]    data_insert;
   logic [K-1:0]    keep_insert;
   logic [C-1:0]    byte_insert_cnt;
   logic            ready_insert;
   logic            valid_in;
   logic [W-1:0]    data_in;
   logic [K-1:0]    keep_in;
   logic            last_in;
   logic            ready_in;
   logic [R-1:0]    grant_id;
   logic            busy;
`ifdef ARB_PKT_CNT_EN
   logic [N*16-1:0] pkt_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   axis_hdr_insert_arbiter #(
      .NUM_REQ (N),
      .DATA_WD (W)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req_hdr_valid   (req_hdr_valid),
      .req_hdr_data    (req_hdr_data),
      .req_hdr_keep    (req_hdr_keep),
      .req_hdr_cnt     (req_hdr_cnt),
      .req_hdr_ready   (req_hdr_ready),
      .req_valid       (req_valid),
      .req_data        (req_data),
      .req_keep        (req_keep),
      .req_last        (req_last),
      .req_ready       (req_ready),
      .valid_insert    (valid_insert),
      .data_insert     (data_insert),
      .keep_insert     (keep_insert),
      .byte_insert_cnt (byte_insert_cnt),
      .ready_insert    (ready_insert),
      .valid_in        (valid_in),
      .data_in         (data_in),
      .keep_in         (keep_in),
      .last_in         (last_in),
      .ready_in        (ready_in),
      .grant_id        (grant_id),
      .busy            (busy)
`ifdef ARB_PKT_CNT_EN
      ,
      .pkt_cnt         (pkt_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] hdr_of(input int i);
      return 32'hA000_0000 + 32'(i);
   endfunction

   function automatic logic [W-1:0] pay_of(input int i);
      return 32'hD000_0000 + 32'(i);
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] bdat [3];
      logic         rpat [5];
      int           b;
      int           g;

      rst_n         = 1'b0;
      req_hdr_valid = '0;
      req_hdr_data  = '0;
      req_hdr_keep  = '0;
      req_hdr_cnt   = '0;
      req_valid     = '0;
      req_data      = '0;
      req_keep      = '0;
      req_last      = '0;
      ready_insert  = 1'b0;
      ready_in      = 1'b0;

      // reset state
      #12;
      check("rst_valid_insert", valid_insert, 0);
      check("rst_valid_in", valid_in, 0);
      check("rst_busy", busy, 0);
      check("rst_grant", grant_id, 0);
      check("rst_hdr_ready", req_hdr_ready, 0);
      check("rst_req_ready", req_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // idle with payload-only valid on src1: no grant
      @(posedge clk); #1;
      ready_insert = 1'b1;
      ready_in     = 1'b1;
      req_valid[1] = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_grant", grant_id, 0);
      check("idle_valid_insert", valid_insert, 0);
      check("idle_valid_in", valid_in, 0);
      check("idle_req_ready", req_ready, 0);

      // single packet from src2
      @(posedge clk); #1;
      req_valid[1]       = 1'b0;
      req_hdr_valid[2]   = 1'b1;
      req_hdr_data[2*W +: W] = 32'hAABBCCDD;
      req_hdr_keep[2*K +: K] = 4'b0011;
      req_hdr_cnt[2*C +: C]  = 2'd2;
      @(negedge clk);
      check("s2_req_cycle_busy", busy, 0);
      check("s2_req_cycle_vins", valid_insert, 0);
      @(posedge clk); #1;
      req_valid[2]       = 1'b1;
      req_data[2*W +: W] = 32'h1111_1111;
      req_keep[2*K +: K] = 4'hF;
      req_last[2]        = 1'b0;
      @(negedge clk);
      check("s2_hdr_grant", grant_id, 2);
      check("s2_hdr_busy", busy, 1);
      check("s2_hdr_vins", valid_insert, 1);
      check("s2_hdr_data", data_insert, 32'hAABBCCDD);
      check("s2_hdr_keep", keep_insert, 4'b0011);
      check("s2_hdr_cnt", byte_insert_cnt, 2);
      check("s2_hdr_ready", req_hdr_ready, 4'b0100);
      check("s2_hdr_vin_gated", valid_in, 0);
      check("s2_hdr_req_ready", req_ready, 0);
      @(posedge clk); #1;
      req_hdr_valid[2] = 1'b0;
      @(negedge clk);
      check("s2_b1_vin", valid_in, 1);
      check("s2_b1_data", data_in, 32'h1111_1111);
      check("s2_b1_keep", keep_in, 4'hF);
      check("s2_b1_last", last_in, 0);
      check("s2_b1_req_ready", req_ready, 4'b0100);
      check("s2_b1_vins", valid_insert, 0);
      @(posedge clk); #1;
      req_data[2*W +: W] = 32'h2222_2222;
      @(negedge clk);
      check("s2_b2_data", data_in, 32'h2222_2222);
      check("s2_b2_last", last_in, 0);
      @(posedge clk); #1;
      req_data[2*W +: W] = 32'h3333_3333;
      req_last[2]        = 1'b1;
      @(negedge clk);
      check("s2_b3_data", data_in, 32'h3333_3333);
      check("s2_b3_last", last_in, 1);
      check("s2_b3_vin", valid_in, 1);
      @(posedge clk); #1;
      req_valid[2] = 1'b0;
      req_last[2]  = 1'b0;
      @(negedge clk);
      check("s2_end_busy", busy, 0);
      check("s2_end_vin", valid_in, 0);
      check("s2_end_grant", grant_id, 2);

      // all four sources request single-beat packets: 0,1,2,3,0
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
         req_hdr_data[i*W +: W] = hdr_of(i);
         req_data[i*W +: W]     = pay_of(i);
      end
      req_hdr_valid = '1;
      req_valid     = '1;
      req_last      = '1;
      @(negedge clk);
      check("rr_pre_busy", busy, 0);
      for (int k = 0; k < 5; k++) begin
         g = k % N;
         @(posedge clk); @(negedge clk);
         check("rr_hdr_grant", grant_id, 64'(g));
         check("rr_hdr_data", data_insert, hdr_of(g));
         check("rr_hdr_ready", req_hdr_ready, 64'(1) << g);
         @(posedge clk); @(negedge clk);
         check("rr_body_vin", valid_in, 1);
         check("rr_body_data", data_in, pay_of(g));
         check("rr_body_req_ready", req_ready, 64'(1) << g);
         check("rr_body_vins", valid_insert, 0);
         @(posedge clk); @(negedge clk);
         check("rr_bubble_busy", busy, 0);
         check("rr_bubble_vin", valid_in, 0);
         check("rr_bubble_vins", valid_insert, 0);
      end
      req_hdr_valid = '0;
      req_valid     = '0;
      req_last      = '0;

      // backpressure on src1 body; src0/src3 hold payload-only valid
      bdat[0] = 32'hB000_0000;
      bdat[1] = 32'hB000_0001;
      bdat[2] = 32'hB000_0002;
      rpat[0] = 1'b1; rpat[1] = 1'b0; rpat[2] = 1'b1; rpat[3] = 1'b0; rpat[4] = 1'b1;
      b = 0;
      @(posedge clk); #1;
      req_hdr_valid[1]       = 1'b1;
      req_hdr_data[1*W +: W] = hdr_of(1);
      req_valid              = 4'b1011;
      req_data[1*W +: W]     = bdat[0];
      ready_in               = 1'b0;
      @(posedge clk); @(negedge clk);
      check("bp_grant", grant_id, 1);
      check("bp_hdr_ready", req_hdr_ready, 4'b0010);
      @(posedge clk); #1;
      req_hdr_valid[1] = 1'b0;
      for (int c = 0; c < 5; c++) begin
         ready_in           = rpat[c];
         req_data[1*W +: W] = bdat[b];
         req_last[1]        = (b == 2);
         @(negedge clk);
         check("bp_req_ready", req_ready, rpat[c] ? 64'h2 : 64'h0);
         check("bp_data", data_in, bdat[b]);
         check("bp_last", last_in, (b == 2) ? 1 : 0);
         @(posedge clk); #1;
         if (rpat[c]) b++;
      end
      req_valid   = '0;
      req_last    = '0;
      ready_in    = 1'b1;
      @(negedge clk);
      check("bp_end_busy", busy, 0);
      check("bp_end_vin", valid_in, 0);

      // header stall on src3 while src0 waits; rr_ptr then wraps to 0
      @(posedge clk); #1;
      ready_insert     = 1'b0;
      req_hdr_valid[3] = 1'b1;
      req_hdr_valid[0] = 1'b1;
      @(posedge clk); #1;
      req_hdr_valid[3] = 1'b0;
      ready_insert     = 1'b1;
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         check("st_vins", valid_insert, 0);
         check("st_grant", grant_id, 3);
         check("st_busy", busy, 1);
         check("st_hdr_ready", req_hdr_ready, 4'b1000);
         @(posedge clk);
      end
      #1;
      req_hdr_valid[3] = 1'b1;
      req_valid[3]     = 1'b1;
      req_last[3]      = 1'b1;
      @(negedge clk);
      check("st_resume_vins", valid_insert, 1);
      check("st_resume_grant", grant_id, 3);
      @(posedge clk); #1;
      req_hdr_valid[3] = 1'b0;
      @(negedge clk);
      check("st_body_vin", valid_in, 1);
      check("st_body_data", data_in, pay_of(3));
      check("st_body_req_ready", req_ready, 4'b1000);
      @(posedge clk); #1;
      req_valid[3] = 1'b0;
      req_last[3]  = 1'b0;
      @(negedge clk);
      check("st_end_busy", busy, 0);
      check("st_end_grant", grant_id, 3);
      @(posedge clk); @(negedge clk);
      check("wrap_grant", grant_id, 0);
      check("wrap_vins", valid_insert, 1);
      check("wrap_data", data_insert, hdr_of(0));

      // reset after 2 of 5 beats of src0
      @(posedge clk); #1;
      req_hdr_valid[0]       = 1'b0;
      req_valid[0]           = 1'b1;
      req_data[0*W +: W]     = 32'hC000_0000;
      @(negedge clk);
      check("rb_b0_data", data_in, 32'hC000_0000);
      @(posedge clk); #1;
      req_data[0*W +: W] = 32'hC000_0001;
      @(negedge clk);
      check("rb_b1_data", data_in, 32'hC000_0001);
      @(posedge clk); #1;
      req_data[0*W +: W] = 32'hC000_0002;
      #1;
      check("rb_pre_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("rb_busy", busy, 0);
      check("rb_vin", valid_in, 0);
      check("rb_req_ready", req_ready, 0);
      check("rb_vins", valid_insert, 0);
      @(negedge clk);
      rst_n         = 1'b1;
      req_valid     = '0;
      req_hdr_valid = 4'b0011;
      @(posedge clk); @(negedge clk);
      check("rb_regrant", grant_id, 0);
      check("rb_regrant_busy", busy, 1);
      check("rb_regrant_ready", req_hdr_ready, 4'b0001);
`ifdef ARB_PKT_CNT_EN
      check("rb_pkt_cnt0", pkt_cnt[15:0], 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
